// File: rtl/cache_cpu_driver.sv
// Drives one load/store at a time into a cache CPU port, waits for the hit
// status to settle, and reports data, miss and timeout with hit/miss statistics.
module cache_cpu_driver #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_WAIT      = 64,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_store,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  loadins,
   output logic                  storeins,
   input  logic                  cache_hit,
   input  logic [DATA_WIDTH-1:0] datcacpu,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_miss,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   // state   | meaning
   // --------+-----------------------------------------------------------
   // ST_IDLE | ready for a command, no cache request active
   // ST_WAIT | request held on the cache port, waiting for cache_hit
   // ST_RESP | one-cycle response strobe, statistics update

   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           miss_r;
   logic           settle_pt;
   logic           sample_ok;
   logic           done;
   logic           tmo;
   logic           miss_now;

   assign settle_pt = (wait_cnt == WCW'(SETTLE_CYCLES));
   assign sample_ok = (wait_cnt >= WCW'(SETTLE_CYCLES));
   assign done      = (state == ST_WAIT) && sample_ok && cache_hit;
   assign tmo       = (state == ST_WAIT) && !done && (wait_cnt == WCW'(MAX_WAIT - 1));
   // the settle sample may land on the completing cycle, so bypass miss_r there
   assign miss_now  = settle_pt ? ~cache_hit : miss_r;

   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (cmd_valid) state_nxt = ST_WAIT;
         ST_WAIT: if (done || tmo) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr        <= '0;
         data_in     <= '0;
         loadins     <= 1'b0;
         storeins    <= 1'b0;
         wait_cnt    <= '0;
         miss_r      <= 1'b0;
         rsp_data    <= '0;
         rsp_miss    <= 1'b0;
         rsp_timeout <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr     <= cmd_addr;
                  data_in  <= cmd_store ? cmd_data : '0;
                  loadins  <= ~cmd_store;
                  storeins <= cmd_store;
                  wait_cnt <= '0;
                  miss_r   <= 1'b0;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + WCW'(1);
               if (settle_pt) miss_r <= ~cache_hit;
               if (done) begin
                  loadins     <= 1'b0;
                  storeins    <= 1'b0;
                  rsp_data    <= loadins ? datcacpu : '0;
                  rsp_miss    <= miss_now;
                  rsp_timeout <= 1'b0;
               end else if (tmo) begin
                  loadins     <= 1'b0;
                  storeins    <= 1'b0;
                  rsp_data    <= '0;
                  rsp_miss    <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
            ST_RESP: begin
               if (!rsp_miss) begin
                  if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
               end else begin
                  if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cache_cpu_driver.md
CACHE_CPU_DRIVER -- requirements
Module: cache_cpu_driver

Interface
REQ-001: Parameter ADDR_WIDTH, default 32, address width of the command and cache request.
REQ-002: Parameter DATA_WIDTH, default 32, data width of store data and load return.
REQ-003: Parameter SETTLE_CYCLES, default 2, cycles from request assertion until cache hit status is first sampled.
REQ-004: Parameter MAX_WAIT, default 64, cycles of request assertion before timeout.
REQ-005: Parameter CNT_WIDTH, default 16, width of the hit and miss statistics counters.
REQ-006: clk  input  1  sole clock; all state updates on rising edge.
REQ-007: rst  input  1  synchronous, active-high reset.
REQ-008: cmd_valid  input  1  command present.
REQ-009: cmd_ready  output  1  block can accept a command.
REQ-010: cmd_store  input  1  1 = store, 0 = load.
REQ-011: cmd_addr  input  ADDR_WIDTH  byte address of the command.
REQ-012: cmd_data  input  DATA_WIDTH  store data; ignored for loads.
REQ-013: addr  output  ADDR_WIDTH  address to the cache CPU port.
REQ-014: data_in  output  DATA_WIDTH  store data to the cache.
REQ-015: loadins  output  1  load request to the cache.
REQ-016: storeins  output  1  store request to the cache.
REQ-017: cache_hit  input  1  cache hit status, 1 = hit / access complete.
REQ-018: datcacpu  input  DATA_WIDTH  load data from the cache.
REQ-019: rsp_valid  output  1  one-cycle response strobe.
REQ-020: rsp_data  output  DATA_WIDTH  load data; 0 for stores and timeouts.
REQ-021: rsp_miss  output  1  first sample of cache_hit was 0.
REQ-022: rsp_timeout  output  1  access did not complete within MAX_WAIT.
REQ-023: busy  output  1  a command is in flight.
REQ-024: hit_count, miss_count  output  CNT_WIDTH each  saturating statistics.

Function
REQ-025: The FSM SHALL have states IDLE, WAIT, RESP; only one command SHALL be in flight.
REQ-026: cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1, moving to WAIT.
REQ-027: On acceptance, addr, data_in and the registered loadins/storeins SHALL update at that same edge; exactly one of loadins or storeins SHALL be 1 throughout WAIT.
REQ-028: Loads SHALL drive data_in to 0.
REQ-029: addr, data_in, loadins and storeins SHALL be held constant throughout WAIT.
REQ-030: wait_cnt SHALL clear to 0 at acceptance and increment by 1 per cycle in WAIT.
REQ-031: At the cycle with wait_cnt == SETTLE_CYCLES, the block SHALL record miss = ~cache_hit.
REQ-032: In WAIT, when wait_cnt >= SETTLE_CYCLES and cache_hit = 1, the block SHALL capture datcacpu (loads only) and move to RESP.
REQ-033: A first-sample hit SHALL yield rsp_valid high in the cycle SETTLE_CYCLES+1 cycles after the accepting edge.
REQ-034: If wait_cnt reaches MAX_WAIT-1 without completion, the block SHALL move to RESP with rsp_timeout = 1, rsp_miss = 1 and rsp_data = 0.
REQ-035: If completion and timeout coincide, completion SHALL win with rsp_timeout = 0.
REQ-036: In RESP, loadins and storeins SHALL be 0 and rsp_valid SHALL be 1 for exactly one cycle, with no backpressure.
REQ-037: The FSM SHALL return from RESP to IDLE unconditionally, giving at least one idle cycle between cache requests.
REQ-038: rsp_data, rsp_miss and rsp_timeout SHALL hold their values until the next RESP.
REQ-039: In RESP, hit_count SHALL increment if rsp_miss = 0, otherwise miss_count SHALL increment; each counter SHALL saturate at all-ones.
REQ-040: cmd_valid outside IDLE SHALL be ignored with no state change.
REQ-041: busy SHALL be 1 in WAIT and RESP.

Reset
REQ-042: With rst = 1 at an edge, the FSM SHALL go to IDLE and all outputs and counters SHALL be 0, except cmd_ready = 1 from the cycle after reset.
REQ-043: Reset during WAIT SHALL abort the access, deassert loadins/storeins at that edge, and produce no response.

Verification
REQ-044: Load at addr 0x0, with cache_hit = 1 from request start and datcacpu = 0x00000002 -> rsp_valid 3 cycles after acceptance, rsp_data = 0x00000002, rsp_miss = 0, hit_count = 1.
REQ-045: Load at addr 0x4, with cache_hit = 0 until 20 cycles after acceptance and datcacpu = 0xDEADBEEF -> rsp_miss = 1, rsp_data = 0xDEADBEEF, miss_count = 1, loadins held for 20 cycles.
REQ-046: Store to 0x8 with data 0xBADDBEEF and cache_hit = 1 -> storeins = 1 and data_in = 0xBADDBEEF during WAIT, rsp_data = 0, hit_count incremented.
REQ-047: Load with cache_hit held at 0 -> rsp_timeout = 1 at wait_cnt = 63, rsp_data = 0, loadins = 0 in the following cycle.
REQ-048: Pulse rst at wait_cnt = 5 of a load -> no rsp_valid, counters = 0, cmd_ready = 1 in the next cycle.
REQ-049: Preload hit_count to 0xFFFF by issuing hits, then issue another hit -> hit_count stays 0xFFFF.
